exc_mode_seq: RTL and testbench



---
 rtl/multi_cpu_pkg.sv | 67 ++++++
 rtl/spsr_bank.sv | 50 +++++
 rtl/exc_mode_seq.sv | 133 +++++++++++++
 tb/tb_exc_mode_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cpu_pkg.sv
// Shared constants for the exception sequencer: mode codes, exception types,
// vectors, LR offsets, reset CPSR and the sequencer state encoding.
package multi_cpu_pkg;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    localparam logic [2:0] EXC_RESET = 3'd0;
    localparam logic [2:0] EXC_UND   = 3'd1;
    localparam logic [2:0] EXC_SVC   = 3'd2;
    localparam logic [2:0] EXC_PABT  = 3'd3;
    localparam logic [2:0] EXC_DABT  = 3'd4;
    localparam logic [2:0] EXC_IRQ   = 3'd5;
    localparam logic [2:0] EXC_FIQ   = 3'd6;

    localparam logic [7:0] VEC_RESET = 8'h00;
    localparam logic [7:0] VEC_UND   = 8'h04;
    localparam logic [7:0] VEC_SVC   = 8'h08;
    localparam logic [7:0] VEC_PABT  = 8'h0C;
    localparam logic [7:0] VEC_DABT  = 8'h10;
    localparam logic [7:0] VEC_IRQ   = 8'h18;
    localparam logic [7:0] VEC_FIQ   = 8'h1C;

    localparam logic [7:0] OFF_RESET = 8'd0;
    localparam logic [7:0] OFF_STD   = 8'd4;
    localparam logic [7:0] OFF_DABT  = 8'd8;

    localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LR,
        ST_PCW,
        ST_RD,
        ST_RPC,
        ST_ACK
    } state_t;

    typedef struct packed {
        logic [4:0] mode;
        logic [7:0] vec;
        logic [7:0] off;
        logic       set_f;
    } exc_info_t;

    // Type 7 and anything unrecognised fall back to the undefined-instruction entry.
    function automatic exc_info_t exc_decode(input logic [2:0] exc_type);
        exc_info_t info;
        info = '{mode: MODE_UND, vec: VEC_UND, off: OFF_STD, set_f: 1'b0};
        case (exc_type)
            EXC_RESET: info = '{mode: MODE_SVC, vec: VEC_RESET, off: OFF_RESET, set_f: 1'b1};
            EXC_SVC:   info = '{mode: MODE_SVC, vec: VEC_SVC,   off: OFF_STD,   set_f: 1'b0};
            EXC_PABT:  info = '{mode: MODE_ABT, vec: VEC_PABT,  off: OFF_STD,   set_f: 1'b0};
            EXC_DABT:  info = '{mode: MODE_ABT, vec: VEC_DABT,  off: OFF_DABT,  set_f: 1'b0};
            EXC_IRQ:   info = '{mode: MODE_IRQ, vec: VEC_IRQ,   off: OFF_STD,   set_f: 1'b0};
            EXC_FIQ:   info = '{mode: MODE_FIQ, vec: VEC_FIQ,   off: OFF_STD,   set_f: 1'b1};
            default: ;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/spsr_bank.sv
// Five banked saved-status registers (fiq, irq, svc, abt, und) selected by mode code.
// Write takes effect at the clock edge; read is combinational and returns 0 for unbanked modes.
module spsr_bank
    import multi_cpu_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            we,
    input  logic [4:0]      w_mode,
    input  logic [SIZE-1:0] w_data,
    input  logic [4:0]      r_mode,
    output logic [SIZE-1:0] r_data
);

    logic [SIZE-1:0] spsr_fiq, spsr_irq, spsr_svc, spsr_abt, spsr_und;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            spsr_fiq <= '0;
            spsr_irq <= '0;
            spsr_svc <= '0;
            spsr_abt <= '0;
            spsr_und <= '0;
        end else if (we) begin
            case (w_mode)
                MODE_FIQ: spsr_fiq <= w_data;
                MODE_IRQ: spsr_irq <= w_data;
                MODE_SVC: spsr_svc <= w_data;
                MODE_ABT: spsr_abt <= w_data;
                MODE_UND: spsr_und <= w_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        r_data = '0;
        case (r_mode)
            MODE_FIQ: r_data = spsr_fiq;
            MODE_IRQ: r_data = spsr_irq;
            MODE_SVC: r_data = spsr_svc;
            MODE_ABT: r_data = spsr_abt;
            MODE_UND: r_data = spsr_und;
            default: ;
        endcase
    end

endmodule

// File: rtl/exc_mode_seq.sv
// Exception entry/return sequencer driving the register file write port while Busy.
// Entry and return each take three cycles after the request (write, PC write, Done).
module exc_mode_seq
    import multi_cpu_pkg::*;
#(
    parameter int SIZE = 32,
    parameter int ADDR = 4
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Exc_Req,
    input  logic [2:0]      Exc_Type,
    input  logic            Ret_Req,
    input  logic            Flag_We,
    input  logic [3:0]      Flags_In,
    input  logic [SIZE-1:0] PC,
    input  logic [SIZE-1:0] R_Data_A,
    output logic [31:0]     CPSR,
    output logic [4:0]      M,
    output logic            Write_Reg,
    output logic            Write_PC,
    output logic [ADDR-1:0] W_Addr,
    output logic [SIZE-1:0] W_Data,
    output logic [SIZE-1:0] PC_New,
    output logic [ADDR-1:0] R_Addr_A,
    output logic            Busy,
    output logic            Done
);

    localparam logic [ADDR-1:0] LR_IDX = ADDR'(14);

    state_t          state, state_nx;
    logic [31:0]     cpsr_q;
    logic [31:0]     cpsr_fl;
    logic [31:0]     spsr_rd;
    logic [SIZE-1:0] lr_q, vec_q;
    exc_info_t       info;
    logic            exc_ok, ret_ok;

    assign info   = exc_decode(Exc_Type);
    assign exc_ok = Exc_Req && !((Exc_Type == EXC_IRQ && cpsr_q[7]) ||
                                 (Exc_Type == EXC_FIQ && cpsr_q[6]));
    assign ret_ok = Ret_Req && (cpsr_q[4:0] != MODE_USR) && (cpsr_q[4:0] != MODE_SYS);
    // SPSR must capture a flag write landing in the same cycle as the entry.
    assign cpsr_fl = Flag_We ? {Flags_In, cpsr_q[27:0]} : cpsr_q;

    spsr_bank #(.SIZE(32)) u_spsr (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .we     (state == ST_IDLE && exc_ok),
        .w_mode (info.mode),
        .w_data (cpsr_fl),
        .r_mode (cpsr_q[4:0]),
        .r_data (spsr_rd)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cpsr_q <= CPSR_RESET;
            lr_q   <= '0;
            vec_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (exc_ok) begin
                        cpsr_q <= {cpsr_fl[31:8], 1'b1, info.set_f | cpsr_fl[6], 1'b0, info.mode};
                        lr_q   <= PC + SIZE'(info.off);
                        vec_q  <= SIZE'(info.vec);
                    end else begin
                        cpsr_q <= cpsr_fl;
                    end
                end
                ST_RD:   lr_q   <= R_Data_A;
                ST_RPC:  cpsr_q <= spsr_rd;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        Write_Reg = 1'b0;
        Write_PC  = 1'b0;
        W_Addr    = '0;
        W_Data    = '0;
        PC_New    = '0;
        R_Addr_A  = '0;
        Done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (exc_ok)      state_nx = ST_LR;
                else if (ret_ok) state_nx = ST_RD;
            end
            ST_LR: begin
                Write_Reg = 1'b1;
                W_Addr    = LR_IDX;
                W_Data    = lr_q;
                state_nx  = ST_PCW;
            end
            ST_PCW: begin
                Write_Reg = 1'b1;
                Write_PC  = 1'b1;
                PC_New    = vec_q;
                state_nx  = ST_ACK;
            end
            ST_RD: begin
                R_Addr_A = LR_IDX;
                state_nx = ST_RPC;
            end
            ST_RPC: begin
                Write_Reg = 1'b1;
                Write_PC  = 1'b1;
                PC_New    = lr_q;
                state_nx  = ST_ACK;
            end
            ST_ACK: begin
                Done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign Busy = (state != ST_IDLE);
    assign CPSR = cpsr_q;
    assign M    = cpsr_q[4:0];

endmodule

// File: tb/tb_exc_mode_seq.sv
// Bench for exc_mode_seq: a queue-based model of pending register-file actions is
// checked against the DUT every cycle, plus hand-computed literal checkpoints.
module tb_exc_mode_seq;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Exc_Req = 1'b0;
    logic [2:0]  Exc_Type = 3'd0;
    logic        Ret_Req = 1'b0;
    logic        Flag_We = 1'b0;
    logic [3:0]  Flags_In = 4'd0;
    logic [31:0] PC = 32'd0;
    logic [31:0] R_Data_A = 32'd0;
    logic [31:0] CPSR;
    logic [4:0]  M;
    logic        Write_Reg, Write_PC, Busy, Done;
    logic [3:0]  W_Addr, R_Addr_A;
    logic [31:0] W_Data, PC_New;

    exc_mode_seq dut (
        .Clk(Clk), .Rst_n(Rst_n), .Exc_Req(Exc_Req), .Exc_Type(Exc_Type),
        .Ret_Req(Ret_Req), .Flag_We(Flag_We), .Flags_In(Flags_In), .PC(PC),
        .R_Data_A(R_Data_A), .CPSR(CPSR), .M(M), .Write_Reg(Write_Reg),
        .Write_PC(Write_PC), .W_Addr(W_Addr), .W_Data(W_Data), .PC_New(PC_New),
        .R_Addr_A(R_Addr_A), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // One entry per future busy cycle: what the register file must see in that cycle.
    typedef struct {
        logic        wr;
        logic        wpc;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pcn;
        logic        rd;
        logic        restore;
        logic        done;
    } step_t;

    function automatic step_t mk(logic wr, logic wpc, logic [3:0] wa, logic [31:0] wd,
                                 logic [31:0] pcn, logic rd, logic rs, logic dn);
        step_t s;
        s.wr = wr; s.wpc = wpc; s.waddr = wa; s.wdata = wd;
        s.pcn = pcn; s.rd = rd; s.restore = rs; s.done = dn;
        return s;
    endfunction

    function automatic void exc_map(input logic [2:0] t, output logic [4:0] md,
                                    output logic [31:0] vec, output logic [31:0] off,
                                    output logic fset);
        fset = 1'b0;
        case (t)
            3'd0: begin md = 5'b10011; vec = 32'h00; off = 0; fset = 1'b1; end
            3'd2: begin md = 5'b10011; vec = 32'h08; off = 4; end
            3'd3: begin md = 5'b10111; vec = 32'h0C; off = 4; end
            3'd4: begin md = 5'b10111; vec = 32'h10; off = 8; end
            3'd5: begin md = 5'b10010; vec = 32'h18; off = 4; end
            3'd6: begin md = 5'b10001; vec = 32'h1C; off = 4; fset = 1'b1; end
            default: begin md = 5'b11011; vec = 32'h04; off = 4; end
        endcase
    endfunction

    step_t       q[$];
    step_t       cur, nxt, e;
    logic [31:0] m_cpsr;
    logic [31:0] m_spsr [32];
    logic [31:0] f, vec, off;
    logic [4:0]  md;
    logic        fset, masked;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_cpsr = 32'h0000_00D3;
            foreach (m_spsr[i]) m_spsr[i] = 32'd0;
            q.delete();
        end else if (q.size() != 0) begin
            cur = q.pop_front();
            if (cur.rd) begin
                nxt = q[0];
                nxt.pcn = R_Data_A;
                q[0] = nxt;
            end
            if (cur.restore) m_cpsr = m_spsr[m_cpsr[4:0]];
        end else begin
            f = m_cpsr;
            if (Flag_We) f[31:28] = Flags_In;
            exc_map(Exc_Type, md, vec, off, fset);
            masked = (Exc_Type == 3'd5 && m_cpsr[7]) || (Exc_Type == 3'd6 && m_cpsr[6]);
            if (Exc_Req && !masked) begin
                m_spsr[md] = f;
                m_cpsr = f;
                m_cpsr[4:0] = md;
                m_cpsr[5] = 1'b0;
                m_cpsr[7] = 1'b1;
                if (fset) m_cpsr[6] = 1'b1;
                q.push_back(mk(1, 0, 4'd14, PC + off, 0, 0, 0, 0));
                q.push_back(mk(1, 1, 4'd0, 0, vec, 0, 0, 0));
                q.push_back(mk(0, 0, 4'd0, 0, 0, 0, 0, 1));
            end else begin
                m_cpsr = f;
                if (Ret_Req && f[4:0] != 5'b10000 && f[4:0] != 5'b11111) begin
                    q.push_back(mk(0, 0, 4'd0, 0, 0, 1, 0, 0));
                    q.push_back(mk(1, 1, 4'd0, 0, 0, 0, 1, 0));
                    q.push_back(mk(0, 0, 4'd0, 0, 0, 0, 0, 1));
                end
            end
        end
    end

    always @(negedge Clk) begin
        e = (q.size() != 0) ? q[0] : mk(0, 0, 4'd0, 0, 0, 0, 0, 0);
        chk("Write_Reg", 32'(Write_Reg), 32'(e.wr));
        chk("Write_PC",  32'(Write_PC),  32'(e.wpc));
        chk("W_Addr",    32'(W_Addr),    32'(e.waddr));
        chk("W_Data",    W_Data,         e.wdata);
        chk("PC_New",    PC_New,         e.pcn);
        chk("R_Addr_A",  32'(R_Addr_A),  e.rd ? 32'd14 : 32'd0);
        chk("Done",      32'(Done),      32'(e.done));
        chk("Busy",      32'(Busy),      32'(q.size() != 0));
        chk("CPSR",      CPSR,           m_cpsr);
        chk("M",         32'(M),         32'(m_cpsr[4:0]));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic req_exc(input logic [2:0] t, input logic [31:0] pc_v);
        Exc_Req = 1'b1; Exc_Type = t; PC = pc_v;
        tick(1);
        Exc_Req = 1'b0;
    endtask

    task automatic req_ret(input logic [31:0] lr_v);
        Ret_Req = 1'b1; R_Data_A = lr_v;
        tick(1);
        Ret_Req = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("rst_cpsr", CPSR, 32'h0000_00D3);
        chk("rst_m", 32'(M), 32'h13);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_wr", 32'(Write_Reg), 32'd0);
        Rst_n = 1'b1;
        tick(2);

        // Return from svc right after reset: SPSR_svc is 0, so I and F clear.
        req_ret(32'h204);
        chk("ret0_raddr", 32'(R_Addr_A), 32'd14);
        tick(1);
        chk("ret0_pcnew", PC_New, 32'h204);
        tick(1);
        chk("ret0_done", 32'(Done), 32'd1);
        chk("ret0_cpsr", CPSR, 32'h0);
        tick(1);

        // irq entry with a simultaneous NZCV write.
        Flag_We = 1'b1; Flags_In = 4'b1010;
        req_exc(3'd5, 32'h300);
        Flag_We = 1'b0;
        chk("irq_cpsr", CPSR, 32'hA000_0092);
        chk("irq_lr", W_Data, 32'h304);
        tick(1);
        chk("irq_vec", PC_New, 32'h18);
        tick(2);
        req_ret(32'h304);
        tick(2);
        chk("irq_ret_cpsr", CPSR, 32'hA000_0000);
        tick(1);

        // svc entry with PC=0x100.
        req_exc(3'd2, 32'h100);
        chk("svc_waddr", 32'(W_Addr), 32'd14);
        chk("svc_lr", W_Data, 32'h104);
        chk("svc_m", 32'(M), 32'h13);
        tick(1);
        chk("svc_vec", PC_New, 32'h08);
        tick(1);
        chk("svc_done", 32'(Done), 32'd1);
        tick(1);

        // Masked irq held for five cycles, then fiq.
        Exc_Req = 1'b1; Exc_Type = 3'd5; PC = 32'h500;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("irq_masked_busy", 32'(Busy), 32'd0);
        end
        req_exc(3'd6, 32'h500);
        chk("fiq_cpsr", CPSR, 32'hA000_00D1);
        tick(1);
        chk("fiq_vec", PC_New, 32'h1C);
        tick(2);

        // Type 7 behaves as und; then return from und.
        req_exc(3'd7, 32'h200);
        chk("und_lr", W_Data, 32'h204);
        chk("und_m", 32'(M), 32'h1B);
        tick(1);
        chk("und_vec", PC_New, 32'h04);
        tick(2);
        req_ret(32'h204);
        tick(1);
        chk("und_ret_pc", PC_New, 32'h204);
        tick(1);
        chk("und_ret_done", 32'(Done), 32'd1);
        chk("und_ret_cpsr", CPSR, 32'hA000_00D1);
        tick(1);

        // Held request gives back-to-back entries.
        Exc_Req = 1'b1; Exc_Type = 3'd2; PC = 32'h600;
        tick(3);
        chk("b2b_done", 32'(Done), 32'd1);
        tick(2);
        chk("b2b_second_lr", 32'(W_Addr), 32'd14);
        tick(3);
        Exc_Req = 1'b0;
        tick(1);

        // Exception wins over a simultaneous return.
        Ret_Req = 1'b1;
        req_exc(3'd4, 32'h40);
        Ret_Req = 1'b0;
        chk("dabt_lr", W_Data, 32'h48);
        chk("dabt_m", 32'(M), 32'h17);
        tick(3);

        // Reset in the middle of an entry.
        req_exc(3'd1, 32'h80);
        chk("rstmid_lr_active", 32'(Write_Reg), 32'd1);
        #2 Rst_n = 1'b0;
        #1;
        chk("rstmid_wr", 32'(Write_Reg), 32'd0);
        chk("rstmid_wdata", W_Data, 32'd0);
        chk("rstmid_busy", 32'(Busy), 32'd0);
        chk("rstmid_cpsr", CPSR, 32'h0000_00D3);
        tick(1);
        #2 Rst_n = 1'b1;
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
